// File: rtl/arbiter_n.sv
// N-requester grant arbiter: fixed-priority or round-robin winner select,
// owner hold with optional fairness timeout, grant parks on the last owner.
module arbiter_n #(
    parameter int N           = 4,
    parameter int MODE        = 1,
    parameter int MAX_HOLD    = 8,
    parameter int RESET_OWNER = 0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_id,
    output logic                 active,
    output logic                 switched
);

    localparam int unsigned NU = N;
    localparam int          IW = $clog2(N);
    localparam int          HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HW-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HW'(MAX_HOLD - 1) : '0;
    localparam logic [N-1:0]  RESET_GNT = {{(N-1){1'b0}}, 1'b1} << RESET_OWNER;

    typedef enum logic {PARK, OWN} state_t;

    state_t        state, state_nxt;
    logic [HW-1:0] hold_cnt, hold_nxt;
    logic [IW-1:0] owner_nxt, winner;
    logic [N-1:0]  others, gnt_nxt;
    logic          any_other, expired, switched_nxt;

    assign others    = req & ~gnt;
    assign any_other = |others;
    assign expired   = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);

    // Round-robin scans owner+1 .. owner+N-1; the owner bit is already clear in others.
    always_comb begin
        logic          found;
        logic [IW-1:0] cand;
        winner = gnt_id;
        found  = 1'b0;
        for (int unsigned i = 0; i < NU; i++) begin
            if (MODE == 0)
                cand = IW'(i);
            else
                cand = IW'((32'(gnt_id) + i + 32'd1) % NU);
            if (!found && others[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= PARK;
            gnt      <= RESET_GNT;
            gnt_id   <= IW'(RESET_OWNER);
            hold_cnt <= '0;
            switched <= 1'b0;
        end else begin
            state    <= state_nxt;
            gnt      <= gnt_nxt;
            gnt_id   <= owner_nxt;
            hold_cnt <= hold_nxt;
            switched <= switched_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        owner_nxt    = gnt_id;
        hold_nxt     = '0;
        switched_nxt = 1'b0;
        if (req[gnt_id] && (!any_other || !expired)) begin
            state_nxt = OWN;
            if (any_other && MAX_HOLD != 0)
                hold_nxt = hold_cnt + 1'b1;
        end else if (any_other) begin
            state_nxt    = OWN;
            owner_nxt    = winner;
            switched_nxt = 1'b1;
        end else begin
            state_nxt = PARK;
        end
    end

    always_comb begin
        gnt_nxt            = '0;
        gnt_nxt[owner_nxt] = 1'b1;
        active             = (state == OWN);
    end

endmodule
